// File: rtl/pulse_event_arbiter.sv
// pulse_event_arbiter: per-channel posedge / negedge / 010-pulse detectors feed
// pending-event latches. A round-robin arbiter serves them to one consumer
// through a registered valid/ready output. Sticky per-channel overflow flags
// record events dropped while an earlier one was still pending.
// Optional feature macro: PEA_TIMESTAMP_EN adds a free-running timestamp
// counter, per-channel capture of the detection time, and the evt_ts output.
module pulse_event_arbiter #(
  parameter int N_CH = 4,
`ifdef PEA_TIMESTAMP_EN
  parameter int TS_W = 16,
`endif
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     a,
  input  logic [2*N_CH-1:0]   cfg_mode,
  output logic                evt_valid,
  output logic [CH_W-1:0]     evt_ch,
`ifdef PEA_TIMESTAMP_EN
  output logic [TS_W-1:0]     evt_ts,
`endif
  input  logic                evt_ready,
  output logic [N_CH-1:0]     ovf,
  input  logic [N_CH-1:0]     ovf_clr
);

  localparam logic [1:0] MODE_POS   = 2'b00;
  localparam logic [1:0] MODE_NEG   = 2'b01;
  localparam logic [1:0] MODE_PULSE = 2'b10;

  logic [N_CH-1:0] a_r;
  logic [N_CH-1:0] a_2r;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] detect;
  logic [N_CH-1:0] grant;
  logic [N_CH-1:0] pending_nxt;
  logic [N_CH-1:0] ovf_nxt;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] grant_idx;
  logic [CH_W-1:0] scan_idx;
  logic            grant_found;
  logic            load;

  // Detect on the live input against one- and two-cycle-old history
  always_comb begin
    detect = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (cfg_mode[2*i +: 2])
        MODE_POS:   detect[i] = a[i] & ~a_r[i];
        MODE_NEG:   detect[i] = ~a[i] & a_r[i];
        MODE_PULSE: detect[i] = ~a[i] & a_r[i] & ~a_2r[i];
        default:    detect[i] = 1'b0;
      endcase
    end
  end

  // Round-robin search starting one past the last granted channel
  always_comb begin
    load        = !evt_valid || evt_ready;
    grant_found = 1'b0;
    grant_idx   = ptr;
    scan_idx    = '0;
    grant       = '0;
    for (int k = 1; k <= N_CH; k++) begin
      scan_idx = CH_W'((int'(ptr) + k) % N_CH);
      if (!grant_found && pending[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    if (load && grant_found) grant[grant_idx] = 1'b1;
  end

  // A new detection re-arms a channel even as it is granted; one arriving on
  // a still-pending, ungranted channel is dropped and flagged (set beats clear)
  always_comb begin
    pending_nxt = (pending & ~grant) | detect;
    ovf_nxt     = (ovf & ~ovf_clr) | (detect & pending & ~grant);
  end

  // Input history, pending latches and sticky overflow flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      a_2r    <= '0;
      pending <= '0;
      ovf     <= '0;
    end else begin
      a_r     <= a;
      a_2r    <= a_r;
      pending <= pending_nxt;
      ovf     <= ovf_nxt;
    end
  end

  // Output register and round-robin pointer; ptr starts at N_CH-1 so ch0 leads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      ptr       <= CH_W'(N_CH - 1);
    end else if (load) begin
      evt_valid <= grant_found;
      if (grant_found) begin
        evt_ch <= grant_idx;
        ptr    <= grant_idx;
      end
    end
  end

`ifdef PEA_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts [N_CH];

  // Free-running counter; a channel captures it only when its pending bit is
  // (re)armed, so an overflowing event keeps the first timestamp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= '0;
      evt_ts <= '0;
      for (int i = 0; i < N_CH; i++) ts[i] <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      for (int i = 0; i < N_CH; i++) begin
        if (detect[i] && (!pending[i] || grant[i])) ts[i] <= ts_cnt;
      end
      if (load && grant_found) evt_ts <= ts[grant_idx];
    end
  end
`endif

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Directed bench for pulse_event_arbiter (N_CH=4). Inputs change 1 time unit
// after each rising edge; outputs are checked at that same point, away from
// the edge. The timestamp section is compiled only with PEA_TIMESTAMP_EN.
module tb_pulse_event_arbiter;

  localparam int N_CH = 4;
  localparam int CH_W = 2;
`ifdef PEA_TIMESTAMP_EN
  localparam int TS_W = 4;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] a;
  logic [2*N_CH-1:0] cfg_mode;
  logic            evt_valid;
  logic [CH_W-1:0] evt_ch;
  logic            evt_ready;
  logic [N_CH-1:0] ovf;
  logic [N_CH-1:0] ovf_clr;
`ifdef PEA_TIMESTAMP_EN
  logic [TS_W-1:0] evt_ts;
`endif

  int vecs = 0;
  int errs = 0;

  pulse_event_arbiter #(
    .N_CH(N_CH)
`ifdef PEA_TIMESTAMP_EN
    , .TS_W(TS_W)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .cfg_mode  (cfg_mode),
    .evt_valid (evt_valid),
    .evt_ch    (evt_ch),
`ifdef PEA_TIMESTAMP_EN
    .evt_ts    (evt_ts),
`endif
    .evt_ready (evt_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    a         = '0;
    cfg_mode  = 8'hFF;
    evt_ready = 1'b0;
    ovf_clr   = '0;
    tick();
    tick();
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_ch",    32'(evt_ch),    0);
    check("rst_ovf",   32'(ovf),       0);
    rst_n = 1'b1;

    // ch0 posedge: valid two cycles after detection, cleared by one ready
    cfg_mode = 8'hFC;
    tick();
    a = 4'b0001;
    tick();
    check("t1_latency_d1", 32'(evt_valid), 0);
    tick();
    check("t1_valid", 32'(evt_valid), 1);
    check("t1_ch",    32'(evt_ch),    0);
    evt_ready = 1'b1;
    tick();
    check("t1_accept", 32'(evt_valid), 0);

    // ch1 pulse 010 fires once
    a = 4'b0000;
    cfg_mode = 8'hFB;
    tick();
    tick();
    a = 4'b0010;
    tick();
    a = 4'b0000;
    tick();
    check("t2_pulse_d1", 32'(evt_valid), 0);
    tick();
    check("t2_pulse_valid", 32'(evt_valid), 1);
    check("t2_pulse_ch",    32'(evt_ch),    1);
    tick();
    check("t2_pulse_done", 32'(evt_valid), 0);
    // 0110 is too wide for a pulse
    a = 4'b0010;
    tick();
    tick();
    a = 4'b0000;
    tick();
    tick();
    check("t2_wide_none_a", 32'(evt_valid), 0);
    tick();
    check("t2_wide_none_b", 32'(evt_valid), 0);
    // same waveform in negedge mode fires on the fall
    cfg_mode = 8'hF7;
    a = 4'b0010;
    tick();
    tick();
    a = 4'b0000;
    tick();
    tick();
    check("t2_neg_valid", 32'(evt_valid), 1);
    check("t2_neg_ch",    32'(evt_ch),    1);
    tick();
    check("t2_neg_done", 32'(evt_valid), 0);

    // fresh pointer, then all four channels at once
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cfg_mode = 8'h00;
    a = 4'b1111;
    tick();
    tick();
    check("t3_rr0", 32'(evt_ch), 0);
    check("t3_v0",  32'(evt_valid), 1);
    tick();
    check("t3_rr1", 32'(evt_ch), 1);
    tick();
    check("t3_rr2", 32'(evt_ch), 2);
    tick();
    check("t3_rr3", 32'(evt_ch), 3);
    check("t3_v3",  32'(evt_valid), 1);
    tick();
    check("t3_drained", 32'(evt_valid), 0);
    a = 4'b0000;
    tick();
    a = 4'b0101;
    tick();
    tick();
    check("t3_wrap_first", 32'(evt_ch), 0);
    tick();
    check("t3_wrap_second", 32'(evt_ch), 2);
    tick();
    check("t3_wrap_done", 32'(evt_valid), 0);

    // back-pressure on ch3: hold stable, overflow, clear, set-beats-clear
    evt_ready = 1'b0;
    a = 4'b0000;
    tick();
    a = 4'b1000;
    tick();
    a = 4'b0000;
    tick();
    check("t4_held_valid", 32'(evt_valid), 1);
    check("t4_held_ch",    32'(evt_ch),    3);
    a = 4'b1000;
    tick();
    check("t4_second_no_ovf", 32'(ovf), 0);
    check("t4_stable_ch",     32'(evt_ch), 3);
    a = 4'b0000;
    tick();
    a = 4'b1000;
    tick();
    check("t4_ovf_set",      32'(ovf), 'h8);
    check("t4_stable_valid", 32'(evt_valid), 1);
    ovf_clr = 4'b1000;
    tick();
    ovf_clr = 4'b0000;
    check("t4_ovf_clr", 32'(ovf), 0);
    a = 4'b0000;
    tick();
    a = 4'b1000;
    ovf_clr = 4'b1000;
    tick();
    check("t4_set_beats_clr", 32'(ovf), 'h8);
    a = 4'b0000;
    tick();
    check("t4_ovf_clr2", 32'(ovf), 0);
    // detection on ch3 in the very cycle ch3 is granted re-arms it, no overflow
    ovf_clr = 4'b0000;
    evt_ready = 1'b1;
    a = 4'b1000;
    tick();
    check("t4_grant_ch",  32'(evt_ch), 3);
    check("t4_grant_ovf", 32'(ovf), 0);
    tick();
    check("t4_rearm_valid", 32'(evt_valid), 1);
    check("t4_rearm_ch",    32'(evt_ch), 3);
    tick();
    check("t4_rearm_done", 32'(evt_valid), 0);

    // async reset mid-handshake with pending 1010
    evt_ready = 1'b0;
    a = 4'b0000;
    tick();
    a = 4'b0001;
    tick();
    tick();
    check("t5_pre_valid", 32'(evt_valid), 1);
    check("t5_pre_ch",    32'(evt_ch), 0);
    a = 4'b1011;
    tick();
    rst_n = 1'b0;
    a = 4'b0000;
    #1;
    check("t5_async_valid", 32'(evt_valid), 0);
    check("t5_async_ch",    32'(evt_ch), 0);
    check("t5_async_ovf",   32'(ovf), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("t5_no_replay", 32'(evt_valid), 0);
    evt_ready = 1'b1;
    a = 4'b1011;
    tick();
    tick();
    check("t5_prio0", 32'(evt_ch), 0);
    tick();
    check("t5_prio1", 32'(evt_ch), 1);
    tick();
    check("t5_prio3", 32'(evt_ch), 3);
    tick();
    check("t5_done", 32'(evt_valid), 0);

`ifdef PEA_TIMESTAMP_EN
    // counter is 0 in the first cycle after release
    rst_n = 1'b0;
    a = 4'b0000;
    cfg_mode = 8'h00;
    evt_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    a = 4'b0001;
    tick();
    a = 4'b0011;
    tick();
    check("ts_ch0",  32'(evt_ch), 0);
    check("ts_max",  32'(evt_ts), 'hF);
    tick();
    check("ts_ch1",  32'(evt_ch), 1);
    check("ts_wrap", 32'(evt_ts), 0);
    evt_ready = 1'b0;
    a = 4'b0111;
    tick();
    a = 4'b0011;
    tick();
    a = 4'b0111;
    tick();
    check("ts_ovf", 32'(ovf), 'h4);
    evt_ready = 1'b1;
    tick();
    check("ts_ovf_ch",   32'(evt_ch), 2);
    check("ts_ovf_keep", 32'(evt_ts), 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
